// File: rtl/irq_encoder_8_if.sv
// Request, mask and handshake signals shared between the sequencer side
// and the interrupt priority encoder.
interface irq_encoder_8_if;
    logic [7:0] req_n;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       gs_n;
    logic [7:0] pending;

    // Sequencer / request source side
    modport master (
        output req_n, mask_we, mask_in, ack,
        input  code, valid, gs_n, pending
    );

    // Encoder side
    modport slave (
        input  req_n, mask_we, mask_in, ack,
        output code, valid, gs_n, pending
    );
endinterface

// File: rtl/irq_encoder_8.sv
// Eight-input interrupt priority encoder: synchronises active-low requests,
// captures falling edges into a pending register, applies a mask and presents
// the highest-priority pending line as a 3-bit code with a valid/ack handshake.
module irq_encoder_8 #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_encoder_8_if.slave    bus
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] hist_q;
    logic [7:0] fall;
    logic [7:0] pending_q;
    logic [7:0] mask_q;
    logic [7:0] eff;
    logic [7:0] clr;
    logic [2:0] sel;
    logic [2:0] code_q;
    logic [2:0] code_next;
    state_t     state_q;
    state_t     state_next;
    logic       valid;

    // Synchroniser chain plus history flop per line, all idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            hist_q <= '1;
        end else begin
            sync_q[0] <= bus.req_n;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = hist_q & ~sync_q[SYNC_STAGES-1];

    // Pending capture; a new edge wins over a same-cycle acknowledge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | fall;
        end
    end

    // Mask register, all lines disabled out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
        end else if (bus.mask_we) begin
            mask_q <= bus.mask_in;
        end
    end

    assign eff = pending_q & ~mask_q;

    // Highest set bit of the effective request vector
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (eff[i]) begin
                sel = i[2:0];
            end
        end
    end

    // Handshake state and presented code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_next;
            code_q  <= code_next;
        end
    end

    // Next state, code capture, valid and pending clear on acknowledge
    always_comb begin
        state_next = state_q;
        code_next  = code_q;
        valid      = 1'b0;
        clr        = '0;
        case (state_q)
            IDLE: begin
                if (|eff) begin
                    state_next = PRESENT;
                    code_next  = sel;
                end
            end
            PRESENT: begin
                valid = 1'b1;
                if (bus.ack) begin
                    state_next = IDLE;
                    clr        = 8'd1 << code_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid;
    assign bus.gs_n    = ~(|eff);
    assign bus.pending = pending_q;

endmodule
